// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: oversampling UART receiver, centre-sampled bits, framing/break detection; UART_RX_MAJORITY_EN adds 3-sample majority vote
module uart_rx_frontend #(
  parameter int DATA_BITS   = 8,
  parameter int MIN_DIVIDER = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_in,
  input  logic [15:0]          i_divider,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_break
);
  localparam int BW = $clog2(DATA_BITS + 1);
  typedef enum logic [2:0] {ARM, IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [15:0] cnt, div_q, div_in;
  logic [BW-1:0] bits;
  logic [DATA_BITS-1:0] sh;
  logic smp, centre, stop_hit;
`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;
  assign smp = (i_in & hist[0]) | (i_in & hist[1]) | (hist[0] & hist[1]);
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) hist <= '1;
    else hist <= {hist[0], i_in};
`else
  assign smp = i_in;
`endif
  assign div_in   = (i_divider < 16'(MIN_DIVIDER)) ? 16'(MIN_DIVIDER) : i_divider;
  assign centre   = (state == START) ? (cnt == (div_q >> 1) - 16'd1) : (cnt == div_q - 16'd1);
  assign stop_hit = (state == STOP) && centre;
  always_comb begin
    state_n = state;
    unique case (state)
      ARM:   state_n = i_in ? IDLE : ARM;
      IDLE:  state_n = i_in ? IDLE : START;
      START: state_n = !centre ? START : (smp ? IDLE : DATA);
      DATA:  state_n = (centre && bits == BW'(DATA_BITS - 1)) ? STOP : DATA;
      STOP:  state_n = !centre ? STOP : (smp ? IDLE : ARM);
      default: state_n = ARM;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state       <= ARM;
      cnt         <= '0;
      div_q       <= 16'(MIN_DIVIDER);
      bits        <= '0;
      sh          <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_break     <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= (state == ARM || state == IDLE || centre) ? '0 : cnt + 16'd1;
      if (state == IDLE && !i_in) div_q <= div_in;
      if (state == START) bits <= '0;
      else if (state == DATA && centre) bits <= bits + BW'(1);
      if (state == DATA && centre) sh <= DATA_BITS'({smp, sh} >> 1);
      if (stop_hit && smp) o_data <= sh;
      o_valid     <= stop_hit && smp;
      o_frame_err <= stop_hit && !smp;
      o_break     <= stop_hit && !smp && sh == '0;
    end
endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb_uart_rx_frontend: directed frames with hand-computed strobe cycles and data
module tb_uart_rx_frontend;
  logic i_clk = 0, i_rst = 1, i_in = 1;
  logic [15:0] i_divider = 16;
  logic [7:0] o_data;
  logic o_valid, o_frame_err, o_break;
  int cyc = 0, n_vec = 0, n_bad = 0, nf = 0, nb = 0, clash = 0, t0;
  int vq[$], dq[$];
  logic [7:0] exp_data;

  uart_rx_frontend dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_in(i_in), .i_divider(i_divider),
    .o_data(o_data), .o_valid(o_valid), .o_frame_err(o_frame_err), .o_break(o_break)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;
  always @(negedge i_clk) begin
    if (o_valid) begin vq.push_back(cyc); dq.push_back(int'(o_data)); end
    if (o_frame_err) nf++;
    if (o_break) nb++;
    if ((o_valid && o_frame_err) || (o_break && !o_frame_err)) clash++;
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  task automatic hold(logic v, int n);
    i_in = v;
    tick(n);
  endtask

  function automatic logic frame_bit(logic [7:0] b, logic stop, int k);
    return (k == 0) ? 1'b0 : (k <= 8) ? b[k-1] : stop;
  endfunction

  task automatic send(logic [7:0] b, logic stop, int div, int spike);
    for (int i = 0; i < 10 * div; i++) begin
      logic v;
      v = frame_bit(b, stop, i / div);
      if (i == spike) v = ~v;
      hold(v, 1);
    end
  endtask

  task automatic clr();
    vq.delete(); dq.delete(); nf = 0; nb = 0;
  endtask

  task automatic pad(int n);
    while (vq.size() < n) begin vq.push_back(-1); dq.push_back(-1); end
  endtask

  initial begin
    tick(3);
    check("rst_data", o_data, 0);
    check("rst_valid", o_valid, 0);
    check("rst_ferr", o_frame_err, 0);
    i_rst = 0;
    while (cyc < 100) tick(1);
    clr();
    send(8'hA5, 1, 16, -1);
    hold(1, 20);
    check("good_count", vq.size(), 1);
    pad(1);
    check("good_cycle", vq[0], 253);
    check("good_data", dq[0], 8'hA5);
    check("good_ferr", nf, 0);

    clr();
    send(8'h00, 1, 16, -1);
    send(8'hFF, 1, 16, -1);
    send(8'h55, 1, 16, -1);
    hold(1, 20);
    check("b2b_count", vq.size(), 3);
    pad(3);
    check("b2b_gap1", vq[1] - vq[0], 160);
    check("b2b_gap2", vq[2] - vq[1], 160);
    check("b2b_d0", dq[0], 8'h00);
    check("b2b_d1", dq[1], 8'hFF);
    check("b2b_d2", dq[2], 8'h55);
    exp_data = 8'h55;

    clr();
    hold(0, 3);
    hold(1, 30);
    check("glitch_strobes", vq.size() + nf, 0);
    check("glitch_hold", o_data, exp_data);
`ifdef UART_RX_MAJORITY_EN
    clr();
    send(8'h0F, 1, 16, 72);
    hold(1, 20);
    check("spike_count", vq.size(), 1);
    pad(1);
    check("spike_data", dq[0], 8'h0F);
    exp_data = 8'h0F;
`endif

    clr();
    send(8'h3C, 0, 16, -1);
    hold(0, 80);
    check("ferr_count", nf, 1);
    check("ferr_break", nb, 0);
    check("ferr_hold", o_data, exp_data);
    hold(1, 200);
    check("ferr_rearm_ferr", nf, 1);
    check("ferr_rearm_valid", vq.size(), 0);

    clr();
    hold(0, 320);
    hold(1, 32);
    check("brk_ferr", nf, 1);
    check("brk_break", nb, 1);
    check("brk_valid", vq.size(), 0);
    clr();
    send(8'h42, 1, 16, -1);
    hold(1, 20);
    pad(1);
    check("brk_next", dq[0], 8'h42);

    clr();
    for (int i = 0; i < 85; i++) hold(frame_bit(8'h99, 1, i / 16), 1);
    i_rst = 1;
    i_in = 0;
    #1;
    check("async_data", o_data, 0);
    check("async_valid", o_valid, 0);
    tick(3);
    i_rst = 0;
    hold(0, 200);
    check("rstlow_strobes", vq.size() + nf + nb, 0);
    hold(1, 1);
    send(8'h99, 1, 16, -1);
    hold(1, 20);
    check("rst_next_count", vq.size(), 1);
    pad(1);
    check("rst_next_data", dq[0], 8'h99);

    clr();
    for (int i = 0; i < 160; i++) begin
      if (i == 40) i_divider = 8;
      hold(frame_bit(8'hC3, 1, i / 16), 1);
    end
    hold(1, 20);
    pad(1);
    check("divchg_data", dq[0], 8'hC3);
    clr();
    t0 = cyc;
    send(8'h3A, 1, 8, -1);
    hold(1, 10);
    pad(1);
    check("div8_cycle", vq[0] - t0, 77);
    check("div8_data", dq[0], 8'h3A);

    clr();
    i_divider = 2;
    t0 = cyc;
    send(8'h81, 1, 4, -1);
    hold(1, 10);
    pad(1);
    check("clamp_cycle", vq[0] - t0, 39);
    check("clamp_data", dq[0], 8'h81);
    check("strobe_exclusive", clash, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
